// File: rtl/regfile_dump_reader_pkg.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader_pkg
// Shared definitions for the register-file debug dump path: the dump FSM state
// encoding and the register-file geometry used by the register file, the
// datapath and the dump reader.
// ----------------------------------------------------------------------------
package regfile_dump_reader_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        READ      = 3'd2,
        SEND      = 3'd3,
        FINISH    = 3'd4
    } state_e;

endpackage : regfile_dump_reader_pkg

// File: rtl/regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader
// Debug reader on a spare register-file read port. On start it halts the core,
// waits for the halt acknowledge, walks indices 0..NUM_REGS-1 streaming each
// (index, value) pair over valid/ready while XOR-accumulating a checksum, then
// releases the halt and pulses done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               dump request (sampled only when idle)
//   halt_req / halt_ack core freeze request / acknowledge
//   reg_addr / reg_data register-file read port (data is combinational)
//   out_valid/out_ready stream handshake
//   out_index/out_data  current beat payload
//   busy, done          activity flag, one-cycle end-of-dump pulse
//   checksum            XOR of all streamed values
// ----------------------------------------------------------------------------
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [ADDR_W-1:0] reg_addr_q,  reg_addr_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] checksum_q,  checksum_d;

    // Index of the next register; the last-index test happens first, so this
    // never wraps.
    logic [ADDR_W-1:0] idx_next;
    assign idx_next = idx_q + ADDR_W'(1);

    // NOTE: every state and datapath register is async-reset so a mid-dump
    // reset leaves no stale beat, index or partial checksum behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            reg_addr_q  <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            reg_addr_q  <= reg_addr_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default on every next-state value keeps this block
        // free of inferred latches.
        state_d     = state_q;
        idx_d       = idx_q;
        reg_addr_d  = reg_addr_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HALT_WAIT;
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end
            HALT_WAIT: begin
                if (halt_ack) begin
                    state_d    = READ;
                    reg_addr_d = idx_q;
                end
            end
            READ: begin
                // reg_addr has been stable for a full cycle; capture the beat.
                out_data_d  = reg_data;
                out_index_d = idx_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    checksum_d  = checksum_q ^ out_data_q;
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d      = idx_next;
                        reg_addr_d = idx_next;
                        state_d    = READ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decoded from the state register: halt is held from the request
    // through the last handshake and dropped during FINISH.
    assign halt_req  = (state_q == HALT_WAIT) || (state_q == READ) || (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign reg_addr  = reg_addr_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign checksum  = checksum_q;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Self-checking bench: a 32-entry register-file array model feeds two dump
// readers (full 32-register and a 4-register build). Expected beats and
// checksums come from the array contents (register 0 reads as zero).
// ----------------------------------------------------------------------------
module tb_regfile_dump_reader;

    localparam int N     = 32;
    localparam int N4    = 4;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start4;
    logic        halt_ack, out_ready;

    logic        halt_req, out_valid, busy, done;
    logic [4:0]  reg_addr, out_index;
    logic [31:0] reg_data, out_data, checksum;

    logic        halt_req4, out_valid4, busy4, done4;
    logic [4:0]  reg_addr4, out_index4;
    logic [31:0] reg_data4, out_data4, checksum4;

    logic [31:0] regs [N];

    int          checks = 0;
    int          errors = 0;
    int          got_idx[$];
    logic [31:0] got_data[$];
    int          done_cnt, done_cyc, idle_cyc, first_valid, last_hs;

    always #5 clk = ~clk;

    assign reg_data  = (reg_addr  == 5'd0) ? 32'd0 : regs[reg_addr];
    assign reg_data4 = (reg_addr4 == 5'd0) ? 32'd0 : regs[reg_addr4];

    regfile_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .reg_addr(reg_addr), .reg_data(reg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    regfile_dump_reader #(.NUM_REGS(N4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .halt_req(halt_req4), .halt_ack(halt_ack),
        .reg_addr(reg_addr4), .reg_data(reg_data4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_index(out_index4), .out_data(out_data4),
        .busy(busy4), .done(done4), .checksum(checksum4)
    );

    // Reference model: what a read of register i returns, and the XOR of the
    // first n such reads.
    function automatic logic [31:0] model_data(input int i);
        return (i == 0) ? 32'd0 : regs[i];
    endfunction

    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s ^= model_data(i);
        return s;
    endfunction

    task automatic randomize_regs();
        for (int i = 0; i < N; i++) regs[i] = $urandom;
    endtask

    // Drives one dump on the full-size reader. Everything is driven and
    // observed at the falling edge; cyc counts rising edges since start was
    // presented. Beats are recorded when valid&&ready will be seen at the
    // next rising edge.
    task automatic run_dump(input int ack_delay, input bit rand_ready,
                            input int restart_a, input int restart_b,
                            input int abort_at, output bit aborted);
        bit          held  = 1'b0;
        bit          ra    = 1'b0;
        bit          rb    = 1'b0;
        logic [4:0]  p_idx = '0;
        logic [31:0] p_data = '0;
        got_idx.delete();
        got_data.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; first_valid = -1; last_hs = -1;
        aborted  = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        halt_ack  = (ack_delay == 0);
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (ack_delay > 0 && cyc <= ack_delay) begin
                checks++;
                if (halt_req !== 1'b1 || out_valid !== 1'b0 || reg_addr !== 5'd0) begin
                    errors++;
                    $display("FAIL halt_wait cyc %0d: halt_req=%b out_valid=%b reg_addr=%0d, want 1 0 0",
                             cyc, halt_req, out_valid, reg_addr);
                end
                if (cyc == ack_delay) halt_ack = 1'b1;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                if (halt_req !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL finish_flags: halt_req=%b busy=%b, want 0 1", halt_req, busy);
                end
            end
            if (held) begin
                checks++;
                if (out_index !== p_idx || out_data !== p_data) begin
                    errors++;
                    $display("FAIL beat_hold: got idx %0d data %h, want idx %0d data %h",
                             out_index, out_data, p_idx, p_data);
                end
            end
            if (abort_at >= 0 && got_idx.size() == abort_at && out_valid) begin
                aborted   = 1'b1;
                out_ready = 1'b0;
                return;
            end
            if (restart_a >= 0 && !ra && got_idx.size() == restart_a && busy) begin
                start = 1'b1; ra = 1'b1;
            end
            if (restart_b >= 0 && !rb && got_idx.size() == restart_b && busy) begin
                start = 1'b1; rb = 1'b1;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_idx.push_back(int'(out_index));
                got_data.push_back(out_data);
                last_hs = cyc + 1;
            end
            held   = out_valid && !out_ready;
            p_idx  = out_index;
            p_data = out_data;
            if (done_cyc > 0 && !busy) begin
                idle_cyc = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL dump_timeout: no return to idle within %0d cycles, beats %0d", LIMIT, got_idx.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; halt_ack = 1'b0; out_ready = 1'b0;
        randomize_regs();
        repeat (3) @(negedge clk);
        checks++;
        if ({halt_req, out_valid, busy, done} !== 4'b0 || reg_addr !== 5'd0 ||
            out_index !== 5'd0 || out_data !== 32'd0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: flags=%b addr=%0d idx=%0d data=%h sum=%h, want all zero",
                     {halt_req, out_valid, busy, done}, reg_addr, out_index, out_data, checksum);
        end
        checks++;
        if ({halt_req4, out_valid4, busy4, done4} !== 4'b0 || checksum4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state4: flags=%b sum=%h, want zero", {halt_req4, out_valid4, busy4, done4}, checksum4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs straight after reset so reg_addr still holds its reset value.
    task automatic test_halt_wait();
        bit ab;
        randomize_regs();
        run_dump(10, 1'b0, -1, -1, -1, ab);
        checks++;
        if (first_valid !== 12) begin
            errors++;
            $display("FAIL halt_latency: first valid at edge %0d, want 12", first_valid);
        end
        checks++;
        if (got_idx.size() != N) begin
            errors++;
            $display("FAIL halt_beats: got %0d beats, want %0d", got_idx.size(), N);
        end
        for (int i = 0; i < got_idx.size() && i < N; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL halt_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        checks++;
        if (checksum !== model_sum(N)) begin
            errors++;
            $display("FAIL halt_checksum: got %h want %h", checksum, model_sum(N));
        end
    endtask

    task automatic test_full_dump();
        bit ab;
        for (int i = 0; i < N; i++) regs[i] = 32'(i) * 32'h0101_0101;
        run_dump(0, 1'b0, -1, -1, -1, ab);
        checks++;
        if (got_idx.size() != N) begin
            errors++;
            $display("FAIL full_beats: got %0d beats, want %0d", got_idx.size(), N);
        end
        for (int i = 0; i < got_idx.size() && i < N; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL full_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        checks++;
        if (first_valid !== 3) begin
            errors++;
            $display("FAIL full_latency: first valid at edge %0d, want 3", first_valid);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 2 * N + 2 || idle_cyc !== 2 * N + 3) begin
            errors++;
            $display("FAIL full_timing: done x%0d at %0d idle at %0d, want x1 at %0d idle at %0d",
                     done_cnt, done_cyc, idle_cyc, 2 * N + 2, 2 * N + 3);
        end
        checks++;
        if (checksum !== model_sum(N)) begin
            errors++;
            $display("FAIL full_checksum: got %h want %h", checksum, model_sum(N));
        end
    endtask

    task automatic test_backpressure();
        bit ab;
        randomize_regs();
        regs[7] = 32'hDEAD_BEEF;
        run_dump(0, 1'b1, -1, -1, -1, ab);
        checks++;
        if (got_idx.size() != N) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats, want %0d", got_idx.size(), N);
        end
        for (int i = 0; i < got_idx.size() && i < N; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL bp_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        checks++;
        if (got_data.size() > 7 && got_data[7] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bp_beat7: got %h want deadbeef", got_data[7]);
        end
        checks++;
        if (checksum !== model_sum(N) || done_cyc !== last_hs) begin
            errors++;
            $display("FAIL bp_checksum: got %h (done at %0d) want %h (done at %0d)",
                     checksum, done_cyc, model_sum(N), last_hs);
        end
    endtask

    task automatic test_ignored_start();
        bit ab;
        randomize_regs();
        run_dump(0, 1'b1, 3, 20, -1, ab);
        checks++;
        if (got_idx.size() != N || done_cnt !== 1) begin
            errors++;
            $display("FAIL restart_ignored: got %0d beats %0d done pulses, want %0d beats 1 pulse",
                     got_idx.size(), done_cnt, N);
        end
        for (int i = 0; i < got_idx.size() && i < N; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL restart_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || checksum !== model_sum(N)) begin
            errors++;
            $display("FAIL restart_idle: busy=%b sum=%h, want 0 %h", busy, checksum, model_sum(N));
        end
    endtask

    task automatic test_reset_abort();
        bit ab;
        randomize_regs();
        run_dump(0, 1'b1, -1, -1, 12, ab);
        checks++;
        if (ab !== 1'b1 || out_index !== 5'd12) begin
            errors++;
            $display("FAIL abort_reach: reached=%b idx=%0d, want 1 12", ab, out_index);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (halt_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL abort_async: halt_req=%b out_valid=%b busy=%b sum=%h, want 0 0 0 0",
                     halt_req, out_valid, busy, checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        randomize_regs();
        run_dump(0, 1'b1, -1, -1, -1, ab);
        checks++;
        if (got_idx.size() != N) begin
            errors++;
            $display("FAIL abort_redump_beats: got %0d beats, want %0d", got_idx.size(), N);
        end
        for (int i = 0; i < got_idx.size() && i < N; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL abort_redump_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        checks++;
        if (checksum !== model_sum(N)) begin
            errors++;
            $display("FAIL abort_redump_checksum: got %h want %h", checksum, model_sum(N));
        end
    endtask

    task automatic test_short_dump();
        int d_cnt = 0;
        int d_cyc = -1;
        int hs    = -1;
        bit fin   = 1'b0;
        randomize_regs();
        regs[1] = 32'hA; regs[2] = 32'h5; regs[3] = 32'hF;
        got_idx.delete();
        got_data.delete();
        @(negedge clk);
        halt_ack  = 1'b1;
        out_ready = 1'b1;
        start4    = 1'b1;
        for (int cyc = 1; cyc <= LIMIT && !fin; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin d_cnt++; d_cyc = cyc; end
            if (out_valid4) begin
                got_idx.push_back(int'(out_index4));
                got_data.push_back(out_data4);
                hs = cyc + 1;
            end
            if (d_cyc > 0 && !busy4) fin = 1'b1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL short_timeout: no return to idle within %0d cycles", LIMIT);
        end
        checks++;
        if (got_idx.size() != N4) begin
            errors++;
            $display("FAIL short_beats: got %0d beats, want %0d", got_idx.size(), N4);
        end
        for (int i = 0; i < got_idx.size() && i < N4; i++) begin
            checks++;
            if (got_idx[i] !== i || got_data[i] !== model_data(i)) begin
                errors++;
                $display("FAIL short_beat %0d: got idx %0d data %h, want idx %0d data %h",
                         i, got_idx[i], got_data[i], i, model_data(i));
            end
        end
        checks++;
        if (checksum4 !== model_sum(N4)) begin
            errors++;
            $display("FAIL short_checksum: got %h want %h", checksum4, model_sum(N4));
        end
        checks++;
        if (d_cnt !== 1 || d_cyc !== hs || d_cyc !== 2 * N4 + 2) begin
            errors++;
            $display("FAIL short_finish: done x%0d at %0d, want x1 at %0d (last handshake %0d)",
                     d_cnt, d_cyc, 2 * N4 + 2, hs);
        end
    endtask

    initial begin
        test_reset();
        test_halt_wait();
        test_full_dump();
        test_backpressure();
        test_ignored_start();
        test_reset_abort();
        test_short_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_dump_reader

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug reader that sits on a spare read port of the 32x32 general-purpose register file. On request it asks the CPU core to halt and waits for acknowledgement. It then walks register indices 0..NUM_REGS-1 and streams each (index, value) pair out over a valid/ready interface, accumulating an XOR checksum. When the walk finishes it releases the halt and pulses done.

Parameters:
NUM_REGS, 32, number of registers to walk (2..32)
ADDR_W, 5, register index width
DATA_W, 32, register data width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  dump request; sampled only in IDLE
halt_req  output  1  request to core to freeze register writes
halt_ack  input  1  core confirms regwrite is suppressed
reg_addr  output  ADDR_W  index driven onto regfile read port
reg_data  input  DATA_W  combinational read data from regfile (register 0 returns 0)
out_valid  output  1  out_index/out_data hold a valid beat
out_ready  input  1  downstream accepts beat
out_index  output  ADDR_W  register index of current beat
out_data  output  DATA_W  register value of current beat
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of dump
checksum  output  DATA_W  XOR of all streamed values; stable from done until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; halt_req, out_valid, busy, done = 0; reg_addr, out_index, out_data, checksum, internal idx = 0.
- FSM states: IDLE, HALT_WAIT, READ, SEND, FINISH.
- IDLE: if start=1 at clock edge: go to HALT_WAIT, set halt_req=1, idx=0, checksum=0.
- HALT_WAIT: halt_req held at 1. On an edge with halt_ack=1, go to READ. No timeout.
- READ: reg_addr=idx, registered. At the edge leaving READ, capture reg_data into out_data, set out_index=idx and out_valid=1, then go to SEND.
- SEND: out_valid, out_index and out_data are held stable until out_ready=1 is sampled. On that handshake edge:
  - checksum ^= out_data and out_valid=0.
  - If idx==NUM_REGS-1, go to FINISH; otherwise idx+1 and go to READ.
- FINISH: lasts exactly one cycle. done=1 and halt_req=0 during this cycle, then go to IDLE.
- reg_addr changes only on the transition into READ.
- halt_ack is sampled only in HALT_WAIT. The core is required to hold regwrite off until halt_req falls. Dropping halt_ack after HALT_WAIT is ignored.
- start while busy=1 is ignored, with no queuing.
- out_ready high while out_valid=0 has no effect.
- Throughput: 2 cycles per register minimum, so 2*NUM_REGS cycles of streaming.
- Latency with halt_ack tied high: start sampled at edge k -> halt_req=1 after k -> READ after k+1 -> first out_valid=1 after k+2.
- The last beat handshakes at edge m. FINISH runs in cycle m..m+1 with done=1 and halt_req=0, and busy=0 after m+1.
- Reset asserted mid-dump aborts immediately to reset values. The core sees halt_req drop asynchronously. No partial checksum is kept.
- Index arithmetic is unsigned ADDR_W. Because the idx==NUM_REGS-1 check occurs before increment, idx never wraps.

Decomposition:
- Shared package holds:
  - State encoding enum {IDLE, HALT_WAIT, READ, SEND, FINISH}.
  - Localparams REG_COUNT=32, REG_ADDR_W=5, REG_DATA_W=32, shared with the register file and datapath.
- The FSM, index counter, output register and checksum live in one module. A separate sub-module is not warranted. The optional stream-side skid buffer is not part of this block.

Test Plan:
1. Preload regs[i]=i*0x01010101 with halt_ack tied 1 and out_ready tied 1, then pulse start. Required response:
   - 32 beats, index 0..31; beat 0 data=0, beat 5 data=0x05050505.
   - first out_valid exactly 3 edges after start.
   - checksum equals the XOR of all preloaded values (0x00000000 for this pattern); done pulses once; total 2*32+3 cycles.
2. Hold halt_ack=0 for 10 cycles after start. Required response: halt_req=1 throughout, reg_addr=0, out_valid=0; streaming begins 2 edges after halt_ack rises.
3. Toggle out_ready pseudo-randomly with regs[7]=0xDEADBEEF. Required response: out_data/out_index stable while valid and not ready; beat 7 data=0xDEADBEEF; no beat dropped or duplicated.
4. Pulse start again at beats 3 and 20 of an active dump. Required response: ignored; exactly 32 beats and one done pulse.
5. Assert rst_n=0 during SEND of beat 12. Required response: halt_req, out_valid, busy drop immediately; a subsequent start produces a full dump from index 0 with a correct checksum.
6. With NUM_REGS=4 and regs[1..3]=0xA, 0x5, 0xF, run a dump. Required response: 4 beats; checksum=0x0; FINISH follows beat 3 handshake by one cycle.
